// File: rtl/mem_arb_if.sv
// Fetch, data and memory request/response bundle for mem_arb.
// slave = arbiter view, master = requesters plus memory (environment) view.
interface mem_arb_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_arb.sv
// Two-port (fetch/data) arbiter onto one memory port, one outstanding transaction, data priority with fetch anti-starvation.
// Latency: grant combinational from m_gnt, response earliest the cycle after grant, passed through combinationally.
// Backpressure: requesters hold req/payload until gnt; optional watchdog (MEM_ARB_TIMEOUT_EN) ends a stuck WAIT with err.
module mem_arb #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input logic       clk,
    input logic       rst,
    mem_arb_if.slave  bus
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_param
        $error("mem_arb: STARVE_LIMIT must be 1..7 and TIMEOUT_CYC 1..255");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] starve_cnt;
    logic [2:0] starve_nxt;
    logic       pick_i;
    logic       pick_d;
    logic       timeout;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wd_cnt;

    // Held at zero in IDLE so every WAIT starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= 8'd0;
        end else if (state == IDLE) begin
            wd_cnt <= 8'd0;
        end else if (!bus.m_rvalid) begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end

    assign timeout = (state != IDLE) && (wd_cnt == WD_LAST) && !bus.m_rvalid;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        starve_nxt   = starve_cnt;
        pick_i       = 1'b0;
        pick_d       = 1'b0;
        bus.m_req    = 1'b0;
        bus.m_we     = 1'b0;
        bus.m_addr   = 32'd0;
        bus.m_wdata  = 32'd0;
        bus.m_wstrb  = 4'd0;
        bus.i_gnt    = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.i_rdata  = 32'd0;
        bus.i_err    = 1'b0;
        bus.d_gnt    = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = 32'd0;
        bus.d_err    = 1'b0;

        // Outputs are forced low for the whole reset pulse, even with requests present.
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    pick_i = bus.i_req && (!bus.d_req || starve_cnt == STARVE_MAX);
                    pick_d = bus.d_req && !pick_i;
                    if (pick_i) begin
                        bus.m_req   = 1'b1;
                        bus.m_addr  = bus.i_addr;
                        bus.m_wstrb = 4'hF;
                        bus.i_gnt   = bus.m_gnt;
                        if (bus.m_gnt) begin
                            state_nxt  = WAIT_I;
                            starve_nxt = 3'd0;
                        end
                    end else if (pick_d) begin
                        bus.m_req   = 1'b1;
                        bus.m_we    = bus.d_we;
                        bus.m_addr  = bus.d_addr;
                        bus.m_wdata = bus.d_wdata;
                        bus.m_wstrb = bus.d_wstrb;
                        bus.d_gnt   = bus.m_gnt;
                        if (bus.m_gnt) begin
                            state_nxt = WAIT_D;
                            if (!bus.i_req) begin
                                starve_nxt = 3'd0;
                            end else if (starve_cnt != STARVE_MAX) begin
                                starve_nxt = starve_cnt + 3'd1;
                            end
                        end
                    end
                end
                WAIT_I: begin
                    if (bus.m_rvalid) begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.m_rdata;
                        state_nxt    = IDLE;
                    end else if (timeout) begin
                        bus.i_rvalid = 1'b1;
                        bus.i_err    = 1'b1;
                        state_nxt    = IDLE;
                    end
                end
                WAIT_D: begin
                    if (bus.m_rvalid) begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.m_rdata;
                        state_nxt    = IDLE;
                    end else if (timeout) begin
                        bus.d_rvalid = 1'b1;
                        bus.d_err    = 1'b1;
                        state_nxt    = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while fetch waits (1..7).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: response watchdog limit in cycles (1..255); used only with MEM_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  in  1  core clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have fetch ports i_req in 1, i_addr in 32 (word read request); i_gnt out 1; i_rvalid out 1; i_rdata out 32; i_err out 1.
REQ-006 SHALL have data ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_wstrb in 4; d_gnt out 1; d_rvalid out 1; d_rdata out 32; d_err out 1.
REQ-007 SHALL have memory ports m_req out 1, m_we out 1, m_addr out 32, m_wdata out 32, m_wstrb out 4; m_gnt in 1; m_rvalid in 1; m_rdata in 32.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT_I, WAIT_D; one outstanding memory transaction at a time.
REQ-009 In IDLE SHALL select a winner combinationally: data wins over fetch unless the starve counter equals STARVE_LIMIT and i_req=1, then fetch wins.
REQ-010 In IDLE with a winner, m_req=1 and m_we/m_addr/m_wdata/m_wstrb SHALL equal the winner's payload; fetch sets m_we=0, m_wdata=0, m_wstrb=4'hF.
REQ-011 Winner's gnt SHALL equal m_gnt in the same cycle; loser's gnt SHALL be 0; requesters hold req and payload until gnt.
REQ-012 On m_gnt in IDLE, FSM SHALL move to WAIT_I or WAIT_D per winner next cycle.
REQ-013 In WAIT states m_req SHALL be 0 and both gnt outputs 0.
REQ-014 In WAIT_x, on m_rvalid=1 the owner's rvalid SHALL be 1 that cycle, its rdata=m_rdata, and FSM returns to IDLE; writes receive rvalid as completion ack.
REQ-015 i_rdata/d_rdata SHALL be 0 whenever the respective rvalid is 0; non-owner rvalid SHALL be 0.
REQ-016 m_rvalid in IDLE SHALL be ignored (no output change).
REQ-017 Minimum transaction latency SHALL be 2 cycles (grant cycle, response earliest next cycle); back-to-back grants allowed on the cycle after a response.
REQ-018 Starve counter (3 bits) SHALL increment on a data grant with i_req=1, clear on a data grant with i_req=0, clear on a fetch grant, saturate at STARVE_LIMIT.
REQ-019 Same-cycle i_req and d_req with counter below limit SHALL grant data only; fetch waits without loss.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE, starve counter 0, watchdog 0; all outputs 0.
REQ-021 Reset during WAIT_x SHALL abandon the transaction; its late m_rvalid falls under REQ-016.

Configuration
REQ-022 Macro MEM_ARB_TIMEOUT_EN defined: an 8-bit watchdog SHALL clear on entry to WAIT_x, increment each WAIT cycle without m_rvalid; on reaching TIMEOUT_CYC the owner SHALL see rvalid=1, err=1, rdata=0 for one cycle and FSM returns to IDLE.
REQ-023 With MEM_ARB_TIMEOUT_EN, m_rvalid in the same cycle as the limit SHALL win: normal response, err=0.
REQ-024 Without MEM_ARB_TIMEOUT_EN: no watchdog logic, i_err=d_err=0 constantly, WAIT states hold until m_rvalid.

Verification
REQ-025 Fetch only: i_req=1, i_addr=0x10, m_gnt=1, m_rvalid next cycle with 0x00500093 -> i_gnt=1 cycle 0, i_rvalid=1 and i_rdata=0x00500093 cycle 1, d_rvalid=0.
REQ-026 Conflict: i_req=d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 -> m_we=1, m_addr=0x200, m_wstrb=4'b0011, d_gnt=1, i_gnt=0.
REQ-027 Starvation: i_req and d_req held high, m_gnt=1, m_rvalid one cycle later each time -> grant order D,D,D,D,I,D,...
REQ-028 Reset: rst pulsed in WAIT_D, then m_rvalid=1 with 0x1234 -> d_rvalid=0, i_rvalid=0, FSM IDLE, all outputs 0 during reset.
REQ-029 With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8: data read granted, no m_rvalid -> 8 cycles later d_rvalid=1, d_err=1, d_rdata=0; repeat with m_rvalid on cycle 8 -> d_err=0.
REQ-030 Spurious m_rvalid=1 in IDLE with no requests -> all rvalid/err/gnt remain 0.
